// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg: shared widths and the queued write-back entry layout for the GRF write-back path.
package grf_wb_pkg;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
        logic              kill;
    } wb_entry_t;
endpackage

// File: rtl/grf_wb_fifo.sv
// grf_wb_fifo: MDU result queue with per-entry kill bits and pending-write lookup for decode.
module grf_wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [REG_AW-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [DATA_W-1:0] push_pc,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_AW-1:0] kill_addr,
    input  logic [REG_AW-1:0] q_addr1,
    input  logic [REG_AW-1:0] q_addr2,
    output wb_entry_t         head,
    output logic              full,
    output logic              empty,
    output logic              hit1,
    output logic              hit2,
    output logic [AW:0]       count
);
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [AW:0]       count_q, count_d;
    logic [DEPTH-1:0]  kill_q, live;
    logic [REG_AW-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] pc_q   [DEPTH];

    assign head_d  = head_q + {{(AW-1){1'b0}}, pop};
    assign tail_d  = tail_q + {{(AW-1){1'b0}}, push};
    assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign head    = '{addr: addr_q[head_q], data: data_q[head_q], pc: pc_q[head_q], kill: kill_q[head_q]};

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_live
        assign live[i] = {1'b0, AW'(i) - head_q} < count_q;
    end

    // Decode lookup: a live, unkilled entry targeting the register still owes a write.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 | (live[i] & ~kill_q[i] & (addr_q[i] == q_addr1));
            hit2 = hit2 | (live[i] & ~kill_q[i] & (addr_q[i] == q_addr2));
        end
        hit1 = hit1 & (q_addr1 != REG_ZERO);
        hit2 = hit2 & (q_addr2 != REG_ZERO);
    end

    // Payload storage needs no reset; only live slots are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
            pc_q[tail_q]   <= push_pc;
        end
    end

    // Pointers, occupancy and kill marking; a same-cycle push lands unkilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            kill_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++)
                if (kill_en && live[i] && addr_q[i] == kill_addr) kill_q[i] <= 1'b1;
            if (push) kill_q[tail_q] <= 1'b0;
        end
    end
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges W-stage and MDU results onto the GRF write port; GRF_WB_BYPASS_EN lets MDU results skip an empty queue.
module grf_wb_arbiter
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_addr,
    input  logic [31:0]   pipe_data,
    input  logic [31:0]   pipe_pc,
    input  logic          mdu_valid,
    output logic          mdu_ready,
    input  logic [4:0]    mdu_addr,
    input  logic [31:0]   mdu_data,
    input  logic [31:0]   mdu_pc,
    input  logic [4:0]    q_addr1,
    input  logic [4:0]    q_addr2,
    output logic          q_hit1,
    output logic          q_hit2,
    output logic          grf_we,
    output logic [4:0]    grf_addr,
    output logic [31:0]   grf_data,
    output logic [31:0]   grf_pc,
    output logic [AW:0]   fifo_count
);
    wb_entry_t         head;
    logic              full, empty, pipe_ok, xfer, mdu_ok, pop, push, byp;
    logic              grf_we_q, grf_we_d;
    logic [REG_AW-1:0] grf_addr_q, grf_addr_d;
    logic [DATA_W-1:0] grf_data_q, grf_data_d, grf_pc_q, grf_pc_d;

    assign mdu_ready = rst_n && !full;
    assign xfer      = mdu_valid && mdu_ready;
    assign mdu_ok    = xfer && mdu_addr != REG_ZERO;
    assign pipe_ok   = pipe_we && pipe_addr != REG_ZERO;
    assign pop       = !pipe_ok && !empty;
`ifdef GRF_WB_BYPASS_EN
    assign byp       = mdu_ok && !pipe_ok && empty;
`else
    assign byp       = 1'b0;
`endif
    assign push      = mdu_ok && !byp;

    grf_wb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (mdu_addr),
        .push_data (mdu_data),
        .push_pc   (mdu_pc),
        .pop       (pop),
        .kill_en   (pipe_ok),
        .kill_addr (pipe_addr),
        .q_addr1   (q_addr1),
        .q_addr2   (q_addr2),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .hit1      (q_hit1),
        .hit2      (q_hit2),
        .count     (fifo_count)
    );

    // Issue priority: pipe, then queue head (killed heads drain silently), then bypass; idle holds fields.
    always_comb begin
        grf_we_d   = pipe_ok ? 1'b1      : pop ? !head.kill : byp;
        grf_addr_d = pipe_ok ? pipe_addr : pop ? head.addr  : byp ? mdu_addr : grf_addr_q;
        grf_data_d = pipe_ok ? pipe_data : pop ? head.data  : byp ? mdu_data : grf_data_q;
        grf_pc_d   = pipe_ok ? pipe_pc   : pop ? head.pc    : byp ? mdu_pc   : grf_pc_q;
    end

    // Output register driving the GRF write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grf_we_q   <= 1'b0;
            grf_addr_q <= '0;
            grf_data_q <= '0;
            grf_pc_q   <= '0;
        end else begin
            grf_we_q   <= grf_we_d;
            grf_addr_q <= grf_addr_d;
            grf_data_q <= grf_data_d;
            grf_pc_q   <= grf_pc_d;
        end
    end

    assign grf_we   = grf_we_q;
    assign grf_addr = grf_addr_q;
    assign grf_data = grf_data_q;
    assign grf_pc   = grf_pc_q;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_grf_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef GRF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        bit          kill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we, mdu_valid, mdu_ready, q_hit1, q_hit2, grf_we;
    logic [4:0]  pipe_addr, mdu_addr, q_addr1, q_addr2, grf_addr;
    logic [31:0] pipe_data, pipe_pc, mdu_data, mdu_pc, grf_data, grf_pc;
    logic [AW:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t        mq[$];
    ent_t        e;
    bit          m_we, m_rdy, m_xf, m_byp;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_pc;

    grf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_we    (pipe_we),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .pipe_pc    (pipe_pc),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_addr   (mdu_addr),
        .mdu_data   (mdu_data),
        .mdu_pc     (mdu_pc),
        .q_addr1    (q_addr1),
        .q_addr2    (q_addr2),
        .q_hit1     (q_hit1),
        .q_hit2     (q_hit2),
        .grf_we     (grf_we),
        .grf_addr   (grf_addr),
        .grf_data   (grf_data),
        .grf_pc     (grf_pc),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mhit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == a && !mq[i].kill) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: the queue holds exactly the pending MDU results in arrival order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_pc = 0;
        end else begin
            m_rdy = mq.size() != DEPTH;
            m_xf  = mdu_valid && m_rdy;
            m_byp = 0;
            if (pipe_we && pipe_addr != 0) begin
                foreach (mq[i]) if (mq[i].addr == pipe_addr) mq[i].kill = 1;
                m_we = 1; m_addr = pipe_addr; m_data = pipe_data; m_pc = pipe_pc;
            end else if (mq.size() != 0) begin
                e = mq.pop_front();
                m_we = !e.kill; m_addr = e.addr; m_data = e.data; m_pc = e.pc;
            end else if (BYP && m_xf && mdu_addr != 0) begin
                m_byp = 1;
                m_we = 1; m_addr = mdu_addr; m_data = mdu_data; m_pc = mdu_pc;
            end else begin
                m_we = 0;
            end
            if (m_xf && mdu_addr != 0 && !m_byp) mq.push_back('{mdu_addr, mdu_data, mdu_pc, 1'b0});
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_grf_we",   grf_we,     m_we);
        chk("m_grf_addr", grf_addr,   m_addr);
        chk("m_grf_data", grf_data,   m_data);
        chk("m_grf_pc",   grf_pc,     m_pc);
        chk("m_count",    fifo_count, mq.size());
        chk("m_ready",    mdu_ready,  rst_n && mq.size() != DEPTH);
        chk("m_hit1",     q_hit1,     mhit(q_addr1));
        chk("m_hit2",     q_hit2,     mhit(q_addr2));
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        pipe_we = 0; pipe_addr = 0; pipe_data = 0; pipe_pc = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0; mdu_pc = 0;
        q_addr1 = 0; q_addr2 = 0;
        rst_n = 1;
        #1 rst_n = 0;
        tick; tick;
        chk("rst_we", grf_we, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", mdu_ready, 0);
        rst_n = 1;
        tick;
        chk("rel_ready", mdu_ready, 1);
        // Pipe only, then addr 0 counts as idle and fields hold.
        pipe_we = 1; pipe_addr = 8; pipe_data = 32'h12345678; pipe_pc = 32'h3000;
        tick;
        chk("pipe_we", grf_we, 1);
        chk("pipe_addr", grf_addr, 8);
        chk("pipe_data", grf_data, 32'h12345678);
        chk("pipe_pc", grf_pc, 32'h3000);
        pipe_addr = 0;
        tick;
        chk("zero_we", grf_we, 0);
        chk("zero_hold", grf_addr, 8);
        // Fill the queue while the pipe writes every cycle.
        pipe_addr = 20; mdu_valid = 1;
        for (int k = 0; k < 4; k++) begin
            mdu_addr = 5'(2 + k); mdu_data = 32'h100 + k; mdu_pc = 32'h4000 + 4 * k; pipe_data = k;
            tick;
        end
        chk("full_count", fifo_count, 4);
        chk("full_ready", mdu_ready, 0);
        pipe_we = 0; mdu_addr = 6; mdu_data = 32'h106; q_addr1 = 3;
        #1 chk("full_hit3", q_hit1, 1);
        tick;
        chk("drain2_addr", grf_addr, 2);
        chk("drain2_data", grf_data, 32'h100);
        chk("drain2_count", fifo_count, 3);
        tick;
        chk("drain3_addr", grf_addr, 3);
        chk("pushpop_count", fifo_count, 3);
        mdu_valid = 0;
        tick; chk("drain4_addr", grf_addr, 4);
        tick; chk("drain5_addr", grf_addr, 5);
        tick;
        chk("drain6_data", grf_data, 32'h106);
        chk("drain_empty", fifo_count, 0);
        tick; chk("drain_idle", grf_we, 0);
        // Kill: newer pipe write to reg 9 supersedes the queued MDU result.
        pipe_we = 1; pipe_addr = 20; mdu_valid = 1; mdu_addr = 9; mdu_data = 32'hAAAA;
        tick;
        mdu_valid = 0; pipe_addr = 9; pipe_data = 32'hBBBB;
        tick;
        chk("kill_data", grf_data, 32'hBBBB);
        chk("kill_count", fifo_count, 1);
        pipe_we = 0; q_addr1 = 9;
        #1 chk("kill_hit", q_hit1, 0);
        tick;
        chk("kill_pop_we", grf_we, 0);
        chk("kill_pop_count", fifo_count, 0);
        // Same-cycle enqueue to the pipe's register survives.
        pipe_we = 1; pipe_addr = 10; pipe_data = 1; mdu_valid = 1; mdu_addr = 10; mdu_data = 2;
        tick;
        chk("same_pipe", grf_data, 1);
        pipe_we = 0; mdu_valid = 0;
        tick;
        chk("same_mdu_we", grf_we, 1);
        chk("same_mdu_data", grf_data, 2);
        // Lookup.
        pipe_we = 1; pipe_addr = 20; mdu_valid = 1; mdu_addr = 17; mdu_data = 32'h1717;
        tick;
        pipe_we = 0; mdu_valid = 0; q_addr1 = 17; q_addr2 = 0;
        #1 chk("look_hit1", q_hit1, 1);
        chk("look_hit2", q_hit2, 0);
        tick;
        chk("look_pop_hit1", q_hit1, 0);
        chk("look_pop_addr", grf_addr, 17);
        // MDU addr 0 is accepted but dropped.
        pipe_we = 1; pipe_addr = 20; mdu_valid = 1; mdu_addr = 0;
        #1 chk("z_ready", mdu_ready, 1);
        tick;
        chk("z_count", fifo_count, 0);
        pipe_we = 0; mdu_valid = 0;
        tick;
        chk("z_we", grf_we, 0);
        // MDU latency from an empty queue with an idle pipe.
        mdu_valid = 1; mdu_addr = 3; mdu_data = 32'h55;
        tick;
        mdu_valid = 0;
        if (BYP) begin
            chk("byp_we", grf_we, 1);
            chk("byp_data", grf_data, 32'h55);
            chk("byp_count", fifo_count, 0);
        end else begin
            chk("lat_we1", grf_we, 0);
            chk("lat_count", fifo_count, 1);
            tick;
            chk("lat_we2", grf_we, 1);
            chk("lat_data", grf_data, 32'h55);
        end
        tick;
        // Reset mid-stream discards queued results.
        pipe_we = 1; pipe_addr = 30; mdu_valid = 1;
        for (int k = 0; k < 3; k++) begin
            mdu_addr = 5'(11 + k); mdu_data = 32'h200 + k;
            tick;
        end
        chk("pre_rst_count", fifo_count, 3);
        rst_n = 0;
        #1 chk("mid_rst_we", grf_we, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ready", mdu_ready, 0);
        pipe_we = 0; mdu_valid = 0;
        tick;
        rst_n = 1;
        tick;
        chk("post_rst_ready", mdu_ready, 1);
        chk("post_rst_we", grf_we, 0);
        tick; tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
